// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver with receive FIFO and valid/ready output.
//            Define UART_RX_PARITY_EN to add an even-parity bit and parity_error.
// Revision : 1.0
// ============================================================================
module uart_rx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       framing_error,
    output logic       overrun,
    output logic       busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_error
`endif
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [CW-1:0] c_bit_reload  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_half_reload = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    logic [1:0]    sync_q, sync_d;
    logic          rs;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          framing_error_q, framing_error_d;
    logic          overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic          par_q, par_d;
    logic          parity_error_q, parity_error_d;
`endif

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          push;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;

    assign rs         = sync_q[1];
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && rx_ready;

    always_comb begin
        sync_d = {sync_q[0], rx};
    end

    // Receive FSM; every bit-period timer counts down to zero at mid-bit.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        bit_idx_d       = bit_idx_q;
        shift_d         = shift_q;
        framing_error_d = 1'b0;
        overrun_d       = 1'b0;
        push            = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d           = par_q;
        parity_error_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rs) begin
                    state_d = S_START;
                    cnt_d   = c_half_reload;
                end
            end
            S_START: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!rs) begin
                    state_d   = S_DATA;
                    cnt_d     = c_bit_reload;
                    bit_idx_d = 3'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    shift_d   = {rs, shift_q[7:1]};
                    cnt_d     = c_bit_reload;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    par_d   = rs;
                    cnt_d   = c_bit_reload;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!rs) begin
                    framing_error_d = 1'b1;
                    state_d         = S_BREAK;
`ifdef UART_RX_PARITY_EN
                end else if (par_q != (^shift_q)) begin
                    parity_error_d = 1'b1;
                    state_d        = S_IDLE;
`endif
                end else if (fifo_full && !pop) begin
                    overrun_d = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    push    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_BREAK: begin
                if (rs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A pop in the same cycle frees the slot a full-FIFO push writes into.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = shift_q;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q          <= 2'b11;
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            framing_error_q <= 1'b0;
            overrun_q       <= 1'b0;
            mem_q           <= '{default: '0};
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
`ifdef UART_RX_PARITY_EN
            par_q           <= 1'b0;
            parity_error_q  <= 1'b0;
`endif
        end else begin
            sync_q          <= sync_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            bit_idx_q       <= bit_idx_d;
            shift_q         <= shift_d;
            framing_error_q <= framing_error_d;
            overrun_q       <= overrun_d;
            mem_q           <= mem_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
`ifdef UART_RX_PARITY_EN
            par_q           <= par_d;
            parity_error_q  <= parity_error_d;
`endif
        end
    end

    assign rx_data       = mem_q[rd_ptr_q[AW-1:0]];
    assign rx_valid      = !fifo_empty;
    assign framing_error = framing_error_q;
    assign overrun       = overrun_q;
    assign busy          = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign parity_error  = parity_error_q;
`endif

endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver, 8N1 framing, LSB first, line idles high.
- Pairs with the fabric top's TX output. Used in the system as a loopback partner and in benches as a TX monitor.
- Oversamples the serial line and recovers bytes.
- Buffers received bytes in a small FIFO and presents them on a valid/ready stream interface.
- Reports framing and overrun errors as single-cycle pulses.

Parameters:
- CLKS_PER_BIT, 217, clk cycles per bit period (25 MHz / 115200); must be >= 4.
- FIFO_DEPTH, 4, receive FIFO entries; must be a power of two, >= 2.

Ports:
- clk  input  1  system clock.
- resetn  input  1  Reset: one clock; synchronous, active-low.
- rx  input  1  serial line, asynchronous to clk.
- rx_data  output  8  byte at FIFO head.
- rx_valid  output  1  FIFO non-empty.
- rx_ready  input  1  consumer accepts rx_data when rx_valid & rx_ready.
- framing_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte dropped because FIFO full.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Synchronizer: rx passes through 2 flops. Both reset to 1. All logic below uses the synchronized value rs.
- Reset values: rx_valid=0, rx_data=0, framing_error=0, overrun=0, busy=0. FSM=IDLE, FIFO empty, counters 0.
- resetn low mid-frame aborts the frame and flushes the FIFO with no error pulse.
- IDLE:
  - rs==0 moves to START and loads bit counter with CLKS_PER_BIT/2 - 1.
- START:
  - At counter 0 (mid start bit), rs==0 moves to DATA with counter CLKS_PER_BIT-1 and bit index 0.
  - rs==1 at that point is a false start: return to IDLE with no pulse.
- DATA:
  - At each counter 0, shift rs into shift[7] (LSB first) and reload the counter.
  - After the 8th sample, go to STOP (or PARITY when enabled).
- STOP, at counter 0 (mid stop bit):
  - rs==1 and FIFO not full: push the byte, go to IDLE.
  - rs==1 and FIFO full: pulse overrun for 1 cycle, drop the byte, go to IDLE.
  - rs==0: pulse framing_error for 1 cycle, drop the byte, go to BREAK.
- BREAK:
  - Wait for rs==1, then go to IDLE. A held-low line yields exactly one framing_error.
- Returning to IDLE at mid stop bit allows back-to-back frames with zero idle time.
- Latency: push occurs on the stop-sample cycle; rx_valid rises the next cycle. End to end is about 2 sync cycles + 9.5 bit times from the start-bit edge.
- FIFO:
  - Registered head; rx_data is stable while rx_valid & !rx_ready.
  - Simultaneous push and pop when full: the pop frees a slot, so the push succeeds with no overrun.
  - Simultaneous push and pop when empty: the byte appears next cycle.
- Pointers: log2(FIFO_DEPTH)+1 bits, wrap naturally. Full when MSBs differ and the rest are equal.
- Errors never enter the FIFO.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state follows DATA and samples one even-parity bit at mid-bit.
  - Output port parity_error (1 bit, reset 0) pulses for 1 cycle at the stop sample if parity mismatched; the byte is dropped.
  - Framing error takes priority: only framing_error pulses if both occur.
- When undefined: no PARITY state, no parity_error port, 8N1 only.

Test Plan:
- CLKS_PER_BIT=8: send 0xA5 with ideal 8N1 timing, rx_ready=1 -> rx_valid for 1 cycle with rx_data=0xA5; no error pulses; busy low again.
- Glitch: rx low for 3 cycles then high -> false start, busy returns low, rx_valid stays 0, no pulses.
- Send 0x3C with the stop bit held low for 20 bit times -> exactly one framing_error pulse; FIFO empty. Then a valid 0x55 -> rx_data=0x55.
- rx_ready=0: send 5 back-to-back bytes 0x01..0x05 with zero idle time, FIFO_DEPTH=4 -> one overrun pulse on the 5th byte. Draining yields 0x01,0x02,0x03,0x04.
- Assert resetn=0 for 1 cycle at mid data bit 4 of a frame -> all outputs at reset values. The remainder of the frame causes no false byte (BREAK/IDLE resync). The next valid frame 0xFF is received.
- UART_RX_PARITY_EN: send 0x07 with parity bit 0 (wrong) -> parity_error pulse, no byte. Send 0x07 with parity bit 1 -> rx_data=0x07.
